lfsr_pattern_counter: RTL and testbench

//  Parametrised LFSR pattern-hit counter. Generalises the fixed 10-bit LFSR + six Moore detectors + match counter.
//  A Fibonacci LFSR steps on each qualified TICK. NCH channels each watch one LFSR bit for a serial PATTERN.
//  The block counts steps with any hit, latches the total at each full LFSR period and restarts.

---
 rtl/lfsr_pattern_counter.sv | 138 +++++++++++++
 tb/tb_lfsr_pattern_counter.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/lfsr_pattern_counter.sv
// LFSR pattern-hit counter: Fibonacci LFSR stepped on qualified TICK, NCH serial detectors, per-period hit total.
// Latency: every step updates LFSR_Q/HIT/COUNT/PERIOD_DONE on the CCLK edge that samples TICK (1 cycle).
// Backpressure: none; TICK is a free-running strobe, and a cycle without a step simply holds all state.
module lfsr_pattern_counter #(
  parameter int                    LFSR_W  = 10,
  parameter logic [LFSR_W-1:0]     TAPS    = 10'h240,
  parameter logic [LFSR_W-1:0]     SEED    = 10'h001,
  parameter int                    NCH     = 6,
  parameter logic [NCH*8-1:0]      CH_BIT  = 48'h05_04_03_02_01_00,
  parameter int                    PAT_LEN = 4,
  parameter logic [PAT_LEN-1:0]    PATTERN = 4'b1011,
  parameter int                    CNT_W   = 15
) (
  input  logic              CCLK,
  input  logic              RESET,
  input  logic              ENGAGE,
  input  logic              TICK,
  input  logic              CLR,
  output logic [LFSR_W-1:0] LFSR_Q,
  output logic [NCH-1:0]    HIT,
  output logic [CNT_W-1:0]  COUNT,
  output logic [CNT_W-1:0]  LAST_COUNT,
  output logic              PERIOD_DONE,
  output logic              SAT
);

  localparam int               FILL_W    = $clog2(PAT_LEN + 1);
  localparam logic [FILL_W-1:0] FILL_FULL = FILL_W'(PAT_LEN);
  localparam logic [CNT_W-1:0]  CNT_MAX   = {CNT_W{1'b1}};

  logic [LFSR_W-1:0]              lfsr_q, lfsr_d;
  logic [NCH-1:0][PAT_LEN-1:0]    hist_q, hist_d;
  logic [FILL_W-1:0]              fill_q, fill_d;
  logic [NCH-1:0]                 hit_q, hit_d;
  logic [CNT_W-1:0]               cnt_q, cnt_d;
  logic [CNT_W-1:0]               last_q, last_d;
  logic                           done_q, done_d;
  logic                           sat_q, sat_d;

  // Candidate values for a step, computed every cycle and only committed when step is high.
  logic                           step;
  logic                           fb;
  logic [LFSR_W-1:0]              lfsr_nx;
  logic [NCH-1:0]                 sel_bit;
  logic [NCH-1:0][PAT_LEN-1:0]    hist_nx;
  logic [FILL_W-1:0]              fill_nx;
  logic [NCH-1:0]                 hit_nx;
  logic [CNT_W-1:0]               cnt_inc;
  logic                           sat_nx;

  // Step datapath: LFSR advance, channel bit taps (pre-advance state), history shift, match and saturating count.
  always_comb begin
    step    = ENGAGE & TICK & ~CLR;
    fb      = ^(lfsr_q & TAPS);
    lfsr_nx = {lfsr_q[LFSR_W-2:0], fb};
    fill_nx = (fill_q == FILL_FULL) ? fill_q : fill_q + FILL_W'(1);
    sel_bit = '0;
    hist_nx = '0;
    hit_nx  = '0;
    for (int i = 0; i < NCH; i++) begin
      // Channel tap index is a parameter byte; decode it as a mux so the index width never matters.
      for (int b = 0; b < LFSR_W; b++) begin
        if (CH_BIT[i*8 +: 8] == 8'(b)) sel_bit[i] = lfsr_q[b];
      end
      hist_nx[i] = {hist_q[i][PAT_LEN-2:0], sel_bit[i]};
      // fill masks the zero-filled history until PAT_LEN real samples have been shifted in.
      hit_nx[i]  = (fill_nx == FILL_FULL) && (hist_nx[i] == PATTERN);
    end
    // Any number of simultaneous channel hits adds exactly one.
    cnt_inc = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + CNT_W'(|hit_nx);
    sat_nx  = sat_q | (cnt_inc == CNT_MAX);
  end

  // Next-state selection: CLR dominates, then step; PERIOD_DONE is a single-cycle pulse.
  always_comb begin
    lfsr_d = lfsr_q;
    hist_d = hist_q;
    fill_d = fill_q;
    hit_d  = hit_q;
    cnt_d  = cnt_q;
    last_d = last_q;
    done_d = 1'b0;
    sat_d  = sat_q;
    if (CLR) begin
      lfsr_d = SEED;
      hist_d = '0;
      fill_d = '0;
      hit_d  = '0;
      cnt_d  = '0;
      sat_d  = 1'b0;
    end else if (step) begin
      lfsr_d = lfsr_nx;
      hist_d = hist_nx;
      fill_d = fill_nx;
      hit_d  = hit_nx;
      cnt_d  = cnt_inc;
      sat_d  = sat_nx;
      // Returning to SEED closes the period; history and fill carry on so patterns can straddle it.
      if (lfsr_nx == SEED) begin
        done_d = 1'b1;
        last_d = cnt_inc;
        cnt_d  = '0;
        sat_d  = 1'b0;
      end
    end
  end

  // State registers with asynchronous active-low reset.
  always_ff @(posedge CCLK or negedge RESET) begin
    if (!RESET) begin
      lfsr_q <= SEED;
      hist_q <= '0;
      fill_q <= '0;
      hit_q  <= '0;
      cnt_q  <= '0;
      last_q <= '0;
      done_q <= 1'b0;
      sat_q  <= 1'b0;
    end else begin
      lfsr_q <= lfsr_d;
      hist_q <= hist_d;
      fill_q <= fill_d;
      hit_q  <= hit_d;
      cnt_q  <= cnt_d;
      last_q <= last_d;
      done_q <= done_d;
      sat_q  <= sat_d;
    end
  end

  assign LFSR_Q      = lfsr_q;
  assign HIT         = hit_q;
  assign COUNT       = cnt_q;
  assign LAST_COUNT  = last_q;
  assign PERIOD_DONE = done_q;
  assign SAT         = sat_q;

endmodule

// File: tb/tb_lfsr_pattern_counter.sv
// Bench for lfsr_pattern_counter: default 10-bit instance, a 3-bit-counter instance and a 4-bit LFSR instance
// share one set of inputs; every cycle all outputs are compared with a queue-based reference model.
module tb_lfsr_pattern_counter;

  logic CCLK, RESET, ENGAGE, TICK, CLR;

  logic [9:0]  lfsr_a;  logic [5:0] hit_a;  logic [14:0] cnt_a, last_a;  logic done_a, sat_a;
  logic [9:0]  lfsr_b;  logic [5:0] hit_b;  logic [2:0]  cnt_b, last_b;  logic done_b, sat_b;
  logic [3:0]  lfsr_c;  logic [0:0] hit_c;  logic [14:0] cnt_c, last_c;  logic done_c, sat_c;

  lfsr_pattern_counter u_dut_a (
    .CCLK(CCLK), .RESET(RESET), .ENGAGE(ENGAGE), .TICK(TICK), .CLR(CLR),
    .LFSR_Q(lfsr_a), .HIT(hit_a), .COUNT(cnt_a), .LAST_COUNT(last_a), .PERIOD_DONE(done_a), .SAT(sat_a));

  lfsr_pattern_counter #(.CNT_W(3)) u_dut_b (
    .CCLK(CCLK), .RESET(RESET), .ENGAGE(ENGAGE), .TICK(TICK), .CLR(CLR),
    .LFSR_Q(lfsr_b), .HIT(hit_b), .COUNT(cnt_b), .LAST_COUNT(last_b), .PERIOD_DONE(done_b), .SAT(sat_b));

  lfsr_pattern_counter #(.LFSR_W(4), .TAPS(4'hC), .SEED(4'h1), .NCH(1), .CH_BIT(8'h00)) u_dut_c (
    .CCLK(CCLK), .RESET(RESET), .ENGAGE(ENGAGE), .TICK(TICK), .CLR(CLR),
    .LFSR_Q(lfsr_c), .HIT(hit_c), .COUNT(cnt_c), .LAST_COUNT(last_c), .PERIOD_DONE(done_c), .SAT(sat_c));

  initial CCLK = 1'b0;
  always #5 CCLK = ~CCLK;

  int checks = 0;
  int failures = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  logic [3:0] pat;
  // Large configuration (instances a and b share LFSR/hit behaviour, differ in counter width).
  logic [9:0] m_lfsr;
  logic [9:0] m_q[$];
  logic [5:0] m_hit;
  int m_cnt, m_last, m_cnt3, m_last3;
  bit m_done, m_sat, m_sat3;
  // Small configuration.
  logic [3:0] s_lfsr;
  logic [3:0] s_q[$];
  logic s_hit;
  int s_cnt, s_last;
  bit s_done, s_sat;

  function automatic logic [9:0] next10(input logic [9:0] v);
    return {v[8:0], v[9] ^ v[6]};
  endfunction
  function automatic logic [3:0] next4(input logic [3:0] v);
    return {v[2:0], v[3] ^ v[2]};
  endfunction

  task automatic model_reset();
    m_lfsr = 10'h001; m_q.delete(); m_hit = '0;
    m_cnt = 0; m_last = 0; m_cnt3 = 0; m_last3 = 0; m_done = 0; m_sat = 0; m_sat3 = 0;
    s_lfsr = 4'h1; s_q.delete(); s_hit = 0; s_cnt = 0; s_last = 0; s_done = 0; s_sat = 0;
  endtask

  task automatic model_clr();
    m_lfsr = 10'h001; m_q.delete(); m_hit = '0; m_cnt = 0; m_cnt3 = 0; m_done = 0; m_sat = 0; m_sat3 = 0;
    s_lfsr = 4'h1; s_q.delete(); s_hit = 0; s_cnt = 0; s_done = 0; s_sat = 0;
  endtask

  task automatic model_step();
    logic [9:0] nl;
    logic [3:0] ns;
    bit h;
    // Large: keep the last four pre-advance states; a hit needs four real samples matching oldest-first.
    m_q.push_back(m_lfsr);
    if (m_q.size() > 4) void'(m_q.pop_front());
    for (int ch = 0; ch < 6; ch++) begin
      h = (m_q.size() == 4);
      for (int k = 0; k < m_q.size(); k++) if (m_q[k][ch] != pat[3-k]) h = 0;
      m_hit[ch] = h;
    end
    if (m_hit != 0) begin
      if (m_cnt < 32767) m_cnt++;
      if (m_cnt3 < 7) m_cnt3++;
    end
    if (m_cnt == 32767) m_sat = 1;
    if (m_cnt3 == 7) m_sat3 = 1;
    nl = next10(m_lfsr);
    m_done = (nl == 10'h001);
    if (m_done) begin
      m_last = m_cnt; m_cnt = 0; m_sat = 0;
      m_last3 = m_cnt3; m_cnt3 = 0; m_sat3 = 0;
    end
    m_lfsr = nl;
    // Small.
    s_q.push_back(s_lfsr);
    if (s_q.size() > 4) void'(s_q.pop_front());
    h = (s_q.size() == 4);
    for (int k = 0; k < s_q.size(); k++) if (s_q[k][0] != pat[3-k]) h = 0;
    s_hit = h;
    if (s_hit && s_cnt < 32767) s_cnt++;
    if (s_cnt == 32767) s_sat = 1;
    ns = next4(s_lfsr);
    s_done = (ns == 4'h1);
    if (s_done) begin s_last = s_cnt; s_cnt = 0; s_sat = 0; end
    s_lfsr = ns;
  endtask

  task automatic check_all();
    chk("a_lfsr", 64'(lfsr_a), 64'(m_lfsr));
    chk("a_hit",  64'(hit_a),  64'(m_hit));
    chk("a_cnt",  64'(cnt_a),  64'(m_cnt));
    chk("a_last", 64'(last_a), 64'(m_last));
    chk("a_done", 64'(done_a), 64'(m_done));
    chk("a_sat",  64'(sat_a),  64'(m_sat));
    chk("b_cnt",  64'(cnt_b),  64'(m_cnt3));
    chk("b_last", 64'(last_b), 64'(m_last3));
    chk("b_sat",  64'(sat_b),  64'(m_sat3));
    chk("c_lfsr", 64'(lfsr_c), 64'(s_lfsr));
    chk("c_hit",  64'(hit_c),  64'(s_hit));
    chk("c_cnt",  64'(cnt_c),  64'(s_cnt));
    chk("c_last", 64'(last_c), 64'(s_last));
    chk("c_done", 64'(done_c), 64'(s_done));
  endtask

  // Drive one cycle's inputs (just after an edge), advance the model for the coming edge, then check.
  task automatic cycle(input logic e, input logic t, input logic c);
    ENGAGE = e; TICK = t; CLR = c;
    if (!RESET) model_reset();
    else if (c) model_clr();
    else if (e && t) model_step();
    else begin m_done = 0; s_done = 0; end
    @(posedge CCLK);
    #1;
    check_all();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog timeout checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  initial begin
    int nd;
    int last_snap;
    logic [9:0] lfsr_snap;
    pat = 4'b1011;
    RESET = 1'b0; ENGAGE = 1'b0; TICK = 1'b0; CLR = 1'b0;
    model_reset();

    // Reset held with ticks running.
    for (int i = 0; i < 5; i++) cycle(1'b1, 1'b1, 1'b0);
    RESET = 1'b1;
    chk("rst_lfsr", 64'(lfsr_a), 64'h001);
    chk("rst_cnt",  64'(cnt_a),  64'h0);

    // Two full periods, one tick every 4 cycles.
    nd = 0;
    for (int i = 0; i < 2046; i++) begin
      cycle(1'b1, 1'b1, 1'b0);
      if (done_a) begin
        nd++;
        chk("b_sat_last", 64'(last_b), 64'd7);
        chk("b_sat_clr",  64'(sat_b),  64'd0);
      end
      if (i == 1000) chk("b_sat_mid", 64'(sat_b), 64'd1);
      for (int j = 0; j < 3; j++) cycle(1'b1, 1'b0, 1'b0);
    end
    chk("period_pulses", 64'(nd), 64'd2);

    // Random engage/tick with occasional CLR.
    for (int i = 0; i < 2500; i++)
      cycle(1'(($urandom % 4) != 0), 1'($urandom % 2), 1'(($urandom % 300) == 0));

    // ENGAGE low: fifty ticks change nothing.
    lfsr_snap = m_lfsr; last_snap = m_last;
    for (int i = 0; i < 50; i++) begin
      cycle(1'b0, 1'b1, 1'b0);
      cycle(1'b0, 1'b0, 1'b0);
    end
    chk("gate_lfsr", 64'(lfsr_a), 64'(lfsr_snap));
    chk("gate_last", 64'(last_a), 64'(last_snap));

    // CLR together with TICK mid-period.
    for (int i = 0; i < 300 + ($urandom % 100); i++) cycle(1'b1, 1'b1, 1'b0);
    last_snap = m_last;
    cycle(1'b1, 1'b1, 1'b1);
    chk("clr_lfsr", 64'(lfsr_a), 64'h001);
    chk("clr_cnt",  64'(cnt_a),  64'h0);
    chk("clr_last", 64'(last_a), 64'(last_snap));

    // Async reset between edges mid-period.
    for (int i = 0; i < 500 + ($urandom % 200); i++) cycle(1'b1, 1'b1, 1'b0);
    #3;
    RESET = 1'b0;
    #1;
    model_reset();
    check_all();
    TICK = 1'b0;
    @(posedge CCLK);
    #1;
    check_all();
    RESET = 1'b1;
    for (int i = 0; i < 40; i++) cycle(1'b1, 1'($urandom % 2), 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
